// File: rtl/md_pkg.sv
// Shared encodings for the mult/div issue controller: FSM states, rstatus codes
// and the writeback record.
package md_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [4:0]  RSTATUS_REG  = 5'd30;
  localparam logic [31:0] RSTATUS_MULT = 32'd4;
  localparam logic [31:0] RSTATUS_DIV  = 32'd5;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } md_wb_t;

  function automatic logic [31:0] rstatus_code(input logic is_div);
    return is_div ? RSTATUS_DIV : RSTATUS_MULT;
  endfunction

endpackage

// File: rtl/md_cycle_counter.sv
// Free-running BUSY cycle counter with synchronous clear/enable and a
// terminal-count flag that is raised in the cycle the count would pass TC_VALUE.
module md_cycle_counter #(
  parameter int CNT_W    = 6,
  parameter int TC_VALUE = 39
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(TC_VALUE);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = en_i && (count_q == TC);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/sequencing controller for the multi-cycle mult/div units.
// Optional watchdog abort in BUSY is enabled by defining MD_TIMEOUT_EN.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        is_div,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

`ifdef MD_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_div_q, is_div_d;
  logic        ctrl_mult_q, ctrl_mult_d;
  logic        ctrl_div_q, ctrl_div_d;
  logic        wb_valid_q, wb_valid_d;
  md_wb_t      wb_q, wb_d;

  logic accept;
  logic cnt_tc;
  logic timeout;
  logic finish;

  md_cycle_counter #(
    .CNT_W    (CNT_W),
    .TC_VALUE (TIMEOUT_CYCLES - 1)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr_i (state_q == START),
    .en_i  (state_q == BUSY),
    .tc_o  (cnt_tc)
  );

  assign accept  = (state_q == IDLE) && valid_in && !flush;
  assign timeout = TIMEOUT_EN && cnt_tc;
  // RDY is only honoured in BUSY; flush always wins over completion.
  assign finish  = (state_q == BUSY) && !flush && (data_resultRDY || timeout);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = flush ? IDLE : BUSY;
      BUSY:    if (flush) state_d = IDLE;
               else if (finish) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    opa_d       = opa_q;
    opb_d       = opb_q;
    rd_d        = rd_q;
    is_div_d    = is_div_q;
    ctrl_mult_d = accept && !is_div;
    ctrl_div_d  = accept && is_div;
    wb_valid_d  = finish;
    wb_d        = wb_q;
    if (accept) begin
      opa_d    = opA;
      opb_d    = opB;
      rd_d     = rd_in;
      is_div_d = is_div;
    end
    if (finish) begin
      // A watchdog abort without RDY is reported like a unit exception.
      if ((data_resultRDY && data_exception) || !data_resultRDY) begin
        wb_d.rd   = RSTATUS_REG;
        wb_d.data = rstatus_code(is_div_q);
      end else begin
        wb_d.rd   = rd_q;
        wb_d.data = data_result;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      rd_q        <= '0;
      is_div_q    <= 1'b0;
      ctrl_mult_q <= 1'b0;
      ctrl_div_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_q        <= '0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      rd_q        <= rd_d;
      is_div_q    <= is_div_d;
      ctrl_mult_q <= ctrl_mult_d;
      ctrl_div_q  <= ctrl_div_d;
      wb_valid_q  <= wb_valid_d;
      wb_q        <= wb_d;
    end
  end

  assign stall     = (state_q == START) || (state_q == BUSY) ||
                     ((state_q == IDLE) && valid_in);
  assign ctrl_MULT = ctrl_mult_q;
  assign ctrl_DIV  = ctrl_div_q;
  assign md_opA    = opa_q;
  assign md_opB    = opb_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_q.rd;
  assign wb_data   = wb_q.data;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl: stimulus pushes expected writebacks,
// a negedge monitor pops and compares them whenever wb_valid is seen.
module tb_md_issue_ctrl;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        is_div = 1'b0;
  logic [31:0] opA = '0;
  logic [31:0] opB = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic [31:0] data_result = '0;
  logic        data_exception = 1'b0;
  logic        data_resultRDY = 1'b0;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_valid;
  logic [31:0] md_opA, md_opB, wb_data;
  logic [4:0]  wb_rd;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  md_issue_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .valid_in       (valid_in),
    .is_div         (is_div),
    .opA            (opA),
    .opB            (opB),
    .rd_in          (rd_in),
    .flush          (flush),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .md_opA         (md_opA),
    .md_opB         (md_opB),
    .stall          (stall),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every writeback strobe must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset && wb_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_data", wb_data, e.data);
      end
    end
  end

  task automatic accept_op(input bit div, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    valid_in = 1'b1;
    is_div   = div;
    opA      = a;
    opB      = b;
    rd_in    = rd;
    @(negedge clock);
    check("stall_accept", 32'(stall), 32'd1);
    tick();
    valid_in = 1'b0;
    is_div   = 1'b0;
    opA      = '0;
    opB      = '0;
    rd_in    = '0;
  endtask

  // Full op: busy_wait = BUSY cycles without RDY before the RDY cycle.
  task automatic run_op(input string tag, input bit div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                        input bit exc, input int busy_wait, input bit stale);
    exp_t e;
    $display("-- %s", tag);
    accept_op(div, a, b, rd);
    if (stale) begin
      data_resultRDY = 1'b1;
      data_result    = 32'hDEAD_BEEF;
    end
    @(negedge clock);
    check("ctrl_DIV_start", 32'(ctrl_DIV), 32'(div));
    check("ctrl_MULT_start", 32'(ctrl_MULT), 32'(!div));
    check("md_opA", md_opA, a);
    check("md_opB", md_opB, b);
    check("stall_start", 32'(stall), 32'd1);
    tick();
    data_resultRDY = 1'b0;
    @(negedge clock);
    check("ctrl_pulse_end", 32'({ctrl_DIV, ctrl_MULT}), 32'd0);
    check("stall_busy", 32'(stall), 32'd1);
    repeat (busy_wait) tick();
    @(negedge clock);
    check("stall_before_rdy", 32'(stall), 32'd1);
    check("md_opA_held", md_opA, a);
    data_resultRDY = 1'b1;
    data_result    = res;
    data_exception = exc;
    e.rd   = exc ? 5'd30 : rd;
    e.data = exc ? (div ? 32'd5 : 32'd4) : res;
    sb.push_back(e);
    tick();
    data_resultRDY = 1'b0;
    data_exception = 1'b0;
    data_result    = '0;
    @(negedge clock);
    check("wb_valid_done", 32'(wb_valid), 32'd1);
    check("stall_done", 32'(stall), 32'd0);
    tick();
    @(negedge clock);
    check("wb_valid_after", 32'(wb_valid), 32'd0);
    tick();
  endtask

  // Flush at the 10th BUSY cycle, optionally together with RDY.
  task automatic flush_op(input string tag, input bit div, input bit with_rdy);
    $display("-- %s", tag);
    accept_op(div, 32'd1234, 32'd56, 5'd17);
    tick();
    repeat (9) tick();
    flush = 1'b1;
    if (with_rdy) begin
      data_resultRDY = 1'b1;
      data_result    = 32'h1111_2222;
    end
    tick();
    flush          = 1'b0;
    data_resultRDY = 1'b0;
    @(negedge clock);
    check("stall_after_flush", 32'(stall), 32'd0);
    check("wb_valid_after_flush", 32'(wb_valid), 32'd0);
    tick();
    @(negedge clock);
    check("wb_valid_flush_late", 32'(wb_valid), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (2) @(negedge clock);
    check("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_rd", 32'(wb_rd), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_md_opA", md_opA, 32'd0);
    check("rst_md_opB", md_opB, 32'd0);
    reset = 1'b1;
    tick();

    run_op("div 100/7",        1'b1, 32'd100,       32'd7, 5'd12, 32'd14,        1'b0, 32, 1'b0);
    run_op("mult -3*5",        1'b0, 32'hFFFF_FFFD, 32'd5, 5'd9,  32'hFFFF_FFF1, 1'b0, 4,  1'b0);
    run_op("div by zero",      1'b1, 32'd50,        32'd0, 5'd7,  32'd0,         1'b1, 6,  1'b0);
    run_op("mult overflow",    1'b0, 32'h7FFF_FFFF, 32'd2, 5'd3,  32'hFFFF_FFFE, 1'b1, 2,  1'b0);
    run_op("mult rd=0",        1'b0, 32'd6,         32'd7, 5'd0,  32'd42,        1'b0, 3,  1'b0);
    run_op("stale rdy div",    1'b1, 32'd81,        32'd9, 5'd20, 32'd9,         1'b0, 5,  1'b1);
    run_op("rdy first busy",   1'b0, 32'd2,         32'd2, 5'd1,  32'd4,         1'b0, 0,  1'b0);

    flush_op("flush 10th busy", 1'b1, 1'b0);
    flush_op("flush with rdy",  1'b0, 1'b1);

    $display("-- flush blocks accept in IDLE");
    valid_in = 1'b1;
    is_div   = 1'b1;
    flush    = 1'b1;
    tick();
    valid_in = 1'b0;
    is_div   = 1'b0;
    flush    = 1'b0;
    @(negedge clock);
    check("idle_flush_no_start", 32'({ctrl_DIV, ctrl_MULT}), 32'd0);
    check("idle_flush_stall", 32'(stall), 32'd0);
    tick();

    $display("-- reset in START");
    accept_op(1'b1, 32'hAAAA_5555, 32'h1234_5678, 5'd4);
    reset = 1'b0;
    #1;
    check("rst_start_ctrl_DIV", 32'(ctrl_DIV), 32'd0);
    check("rst_start_md_opA", md_opA, 32'd0);
    check("rst_start_stall", 32'(stall), 32'd0);
    #2 reset = 1'b1;
    tick();

    $display("-- reset mid-BUSY");
    accept_op(1'b0, 32'hCAFE_F00D, 32'h0BAD_BEEF, 5'd8);
    tick();
    repeat (4) tick();
    reset = 1'b0;
    #1;
    check("rst_busy_stall", 32'(stall), 32'd0);
    check("rst_busy_md_opA", md_opA, 32'd0);
    check("rst_busy_md_opB", md_opB, 32'd0);
    #2 reset = 1'b1;
    tick();
    @(negedge clock);
    check("rst_busy_idle_stall", 32'(stall), 32'd0);
    tick();

`ifdef MD_TIMEOUT_EN
    begin
      exp_t e;
      int   busy_cnt;
      $display("-- watchdog timeout");
      accept_op(1'b0, 32'd1, 32'd1, 5'd11);
      tick();
      e.rd   = 5'd30;
      e.data = 32'd4;
      sb.push_back(e);
      busy_cnt = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clock);
        if (!stall) break;
        busy_cnt++;
        tick();
      end
      check("timeout_busy_cycles", 32'(busy_cnt), 32'(TIMEOUT));
      tick();
      tick();
    end
`else
    $display("-- no watchdog: BUSY waits");
    accept_op(1'b0, 32'd1, 32'd1, 5'd11);
    tick();
    repeat (TIMEOUT + 10) tick();
    @(negedge clock);
    check("no_timeout_stall", 32'(stall), 32'd1);
    check("no_timeout_wb_valid", 32'(wb_valid), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clock);
    check("no_timeout_flush_stall", 32'(stall), 32'd0);
    tick();
`endif

    repeat (3) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
